// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I pipeline interlock controller.
// Holds the opcode-class and funct3 encodings, the controller state enum and the scoreboard counter type.
package rv32i_pkg;

  localparam logic [1:0] AR_TYPE = 2'd0;
  localparam logic [1:0] M_TYPE  = 2'd1;
  localparam logic [1:0] BR_TYPE = 2'd2;
  localparam logic [1:0] SH_TYPE = 2'd3;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam int SB_CNTW = 2;
  typedef logic [SB_CNTW-1:0] sb_cnt_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } haz_state_t;

endpackage

// File: rtl/rv32i_scoreboard.sv
// Per-register count of in-flight writes for the RV32I interlock.
// x0 is never counted; simultaneous inc/dec of one register cancels, and a decrement at zero is ignored.
module rv32i_scoreboard
  import rv32i_pkg::*;
#(
  parameter int NREG = 32,
  parameter int CNTW = SB_CNTW
) (
  input  logic            clk,
  input  logic            RN,
  input  logic [4:0]      rd_a_idx,
  input  logic [4:0]      rd_b_idx,
  output logic [CNTW-1:0] rd_a_cnt,
  output logic [CNTW-1:0] rd_b_cnt,
  input  logic            inc_en,
  input  logic [4:0]      inc_idx,
  input  logic            dec_en,
  input  logic [4:0]      dec_idx,
  output logic [NREG-1:0] busy_vec,
  output logic            all_clear
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0] cnt [NREG];
  logic [NREG-1:0] inc_hit;
  logic [NREG-1:0] dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    if (inc_en && inc_idx != 5'd0) inc_hit[inc_idx] = 1'b1;
    if (dec_en && dec_idx != 5'd0) dec_hit[dec_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_hit[r] && !dec_hit[r] && cnt[r] != CNT_MAX)
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec_hit[r] && !inc_hit[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  assign rd_a_cnt = cnt[rd_a_idx];
  assign rd_b_cnt = cnt[rd_b_idx];

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) busy_vec[r] = (cnt[r] != '0);
  end

  assign all_clear = ~|busy_vec;

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Interlock and sequencing controller for the five-stage RV32I core (no forwarding).
// Optional performance counters are built only when RV32I_HAZ_PERF_EN is defined.
//
//   state  | meaning
//   RUN    | normal issue, stall on RAW hazard, branch-taken squash
//   FLUSH  | one cycle killing the instruction fetched before redirect
//   DRAIN  | issue stopped, waiting for all in-flight writes to retire
//   HALTED | pipeline empty, drained asserted until drain_req drops
module rv32i_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNTW  = 2,
  parameter int PERFW = 16
) (
  input  logic             clk,
  input  logic             RN,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wr,
  input  logic             ex_br_taken,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             drain_req,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             issue,
  output logic             drained,
  output logic [NREG-1:0]  busy_vec,
  output logic [PERFW-1:0] stall_cycles,
  output logic [PERFW-1:0] flush_count
);

  haz_state_t      state;
  logic [CNTW-1:0] rs1_cnt;
  logic [CNTW-1:0] rs2_cnt;
  logic            all_clear;
  logic            haz;

  rv32i_scoreboard #(
    .NREG (NREG),
    .CNTW (CNTW)
  ) u_sb (
    .clk       (clk),
    .RN        (RN),
    .rd_a_idx  (id_rs1),
    .rd_b_idx  (id_rs2),
    .rd_a_cnt  (rs1_cnt),
    .rd_b_cnt  (rs2_cnt),
    .inc_en    (issue & id_wr),
    .inc_idx   (id_rd),
    .dec_en    (wb_valid),
    .dec_idx   (wb_rd),
    .busy_vec  (busy_vec),
    .all_clear (all_clear)
  );

  // A WB retiring this cycle still counts: the regfile only updates at the edge.
  assign haz = id_valid &
               (((id_rs1 != 5'd0) && (rs1_cnt != '0)) ||
                (id_use_rs2 && (id_rs2 != 5'd0) && (rs2_cnt != '0)));

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    issue  = 1'b0;
    case (state)
      RUN: begin
        issue  = id_valid & ~haz & ~ex_br_taken;
        stall  = haz & ~ex_br_taken;
        bubble = (haz & ~ex_br_taken) | ex_br_taken;
        flush  = ex_br_taken;
      end
      FLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
      end
      DRAIN, HALTED: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ex_br_taken)    state <= FLUSH;
          else if (drain_req) state <= DRAIN;
        end
        FLUSH: state <= drain_req ? DRAIN : RUN;
        DRAIN: begin
          if (!drain_req) begin
            state <= RUN;
          end else if (all_clear) begin
            state   <= HALTED;
            drained <= 1'b1;
          end
        end
        HALTED: begin
          if (!drain_req) begin
            state   <= RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

`ifdef RV32I_HAZ_PERF_EN
  logic [PERFW-1:0] stall_q;
  logic [PERFW-1:0] flush_q;

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state == RUN && stall && stall_q != '1)       stall_q <= stall_q + 1'b1;
      if (state == RUN && ex_br_taken && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
